// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and counter sizing for the bit-serial adder
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/serial_adder_fa_bit_cell.sv
// fa_bit_cell: gate-level one-bit full adder
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    logic x;
    assign x  = a ^ b;
    assign s  = x ^ c;
    assign co = (a & b) | (x & c);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder with start/busy/done handshake
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = cnt_w(WIDTH);
    state_t state;
    logic [WIDTH-1:0] sa, sb, sr, sr_next;
    logic [CW-1:0] count;
    logic c, s, co;
    fa_bit_cell u_cell (.a(sa[0]), .b(sb[0]), .c(c), .s(s), .co(co));
    // shift form stays legal for WIDTH=1, where sr>>1 is simply zero
    assign sr_next = (WIDTH'(s) << (WIDTH - 1)) | (sr >> 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            c     <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    sr    <= sr_next;
                    c     <= co;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        sum   <= sr_next;
                        cout  <= co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        c     <= cin;
                        sr    <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of the 8-bit and 1-bit serial adder builds
module tb_serial_adder;
    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, cin = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic busy, done, cout;
    logic [7:0] sum;
    logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic busy1, done1, cout1;
    logic [0:0] sum1;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );
    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [7:0] es, input logic ec, input string tag);
        a = va; b = vb; cin = vc; start = 1'b1;
        tick();
        start = 1'b0; a = ~va; b = ~vb; cin = ~vc;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_nodone"}, done, 0);
            tick();
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_lo"}, busy, 0);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        tick();
        chk({tag, "_done_lo"}, done, 0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        tick();
        chk("idle_busy", busy, 0);

        run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5a_3c");
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");

        // start during RUN must be ignored
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'h11; b = 8'h22; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("ign_done", done, 1);
        chk("ign_sum", sum, 8'h02);
        chk("ign_cout", cout, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ign_no_second_done", done, 0);
            chk("ign_idle", busy, 0);
        end

        // reset at E4 aborts the run
        a = 8'h5A; b = 8'h3C; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_done", done, 0);
        end
        run8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "post_abort");

        // start held through DONE: back-to-back operations
        a = 8'h80; b = 8'h80; cin = 1'b1; start = 1'b1;
        tick();
        a = 8'h0F; b = 8'hF0; cin = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("b2b_done1", done, 1);
        chk("b2b_sum1", sum, 8'h01);
        chk("b2b_cout1", cout, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            chk("b2b_busy", busy, 1);
            chk("b2b_gap_nodone", done, 0);
            chk("b2b_hold_sum", sum, 8'h01);
            chk("b2b_hold_cout", cout, 1);
        end
        tick();
        chk("b2b_done2", done, 1);
        chk("b2b_sum2", sum, 8'hFF);
        chk("b2b_cout2", cout, 0);
        tick();
        chk("b2b_end", done, 0);

        // WIDTH=1 full-adder truth table
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            logic [1:0] e;
            v = 3'(k);
            e = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk("w1_busy", busy1, 1);
            chk("w1_nodone", done1, 0);
            tick();
            chk("w1_done", done1, 1);
            chk("w1_sum", sum1, e[0]);
            chk("w1_cout", cout1, e[1]);
            tick();
            chk("w1_done_lo", done1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder built around a single one-bit full-adder cell, which adds one bit per clock. Operand shift registers and a carry flip-flop feed the cell.
- Adds two WIDTH-bit operands plus carry-in over WIDTH clock cycles, LSB first.
- Uses a start/busy/done handshake.
- Serves as the area-cheap alternative to a ripple-carry chain of full-adder cells, and as the datapath stage that feeds the one-bit cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request; sampled only when the block is idle or in the done cycle.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; sum/cout are valid from this cycle onward.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered final carry; held until the next completion.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry FF and bit counter cleared.
  - Reset has priority over every other event, including mid-operation: the operation is aborted and no done is issued.
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. On start=1 at edge E0:
    - capture a and b into shift registers sa/sb, cin into carry FF c;
    - set count=0; go to RUN.
  - RUN: busy=1. At each edge, for bit k:
    - the cell computes s=sa[0]^sb[0]^c and co=(sa[0]&sb[0])|((sa[0]^sb[0])&c);
    - sa and sb shift right by 1 (zero fill);
    - s shifts into the MSB of result shift register sr (sr shifts right);
    - c<=co; count<=count+1.
    - The edge with count==WIDTH-1 is the last bit: sum<=final sr contents including that bit, cout<=co, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Latency:
  - start accepted at E0; bits processed at E1..E_WIDTH.
  - done=1 and sum/cout valid in the cycle after E_WIDTH.
  - Throughput: one result per WIDTH+1 cycles.
- start in RUN is ignored; operands are not re-sampled.
- a, b and cin may change freely after the accepting edge.
- sum/cout change only at the last RUN edge. They are stable through a later operation's RUN phase.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1); no overflow flag.
- Counter width is clog2(WIDTH+1). WIDTH=1 gives a single RUN cycle.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the counter-width function.
- One natural sub-module: fa_bit_cell, a combinational gate-level one-bit full adder (two xor, two and, one or).
  - Instantiated once. The top level holds the FSM, shift registers, carry FF and output registers.

Test Plan:
- WIDTH=8, a=8'h5A, b=8'h3C, cin=0, start one cycle -> busy high 8 cycles; done pulse in the cycle after E8; sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start re-asserted with a=8'h11, b=8'h22 during RUN of 8'h01+8'h01 -> ignored; result sum=8'h02, cout=0; no second done.
- rst=1 at E4 of a run -> busy=0, sum=0, cout=0 next cycle; no done pulse; a subsequent start of 8'h10+8'h20 gives 8'h30.
- start held high through the DONE cycle -> second operation begins immediately. First result stays visible until the second done; two done pulses 9 cycles apart.
- WIDTH=1 build, all 8 (a,b,cin) combinations -> each done one cycle after the single RUN cycle; sum/cout match the full-adder truth table.
